// File: rtl/seg7_pkg.sv
// Segment patterns for a 7-segment display, bit order abcdefg (MSB = a), active-high.
package seg7_pkg;

   localparam logic [6:0] SEG_0     = 7'b1111110;
   localparam logic [6:0] SEG_1     = 7'b0110000;
   localparam logic [6:0] SEG_2     = 7'b1101101;
   localparam logic [6:0] SEG_3     = 7'b1111001;
   localparam logic [6:0] SEG_4     = 7'b0110011;
   localparam logic [6:0] SEG_5     = 7'b1011011;
   localparam logic [6:0] SEG_6     = 7'b1011111;
   localparam logic [6:0] SEG_7     = 7'b1110000;
   localparam logic [6:0] SEG_8     = 7'b1111111;
   localparam logic [6:0] SEG_9     = 7'b1111011;
   localparam logic [6:0] SEG_A     = 7'b1110111;
   localparam logic [6:0] SEG_B     = 7'b0011111;
   localparam logic [6:0] SEG_C     = 7'b1001110;
   localparam logic [6:0] SEG_D     = 7'b0111101;
   localparam logic [6:0] SEG_E     = 7'b1001111;
   localparam logic [6:0] SEG_F     = 7'b1000111;
   localparam logic [6:0] SEG_BLANK = 7'b0000000;

endpackage

// File: rtl/seg7_hex_decode.sv
// Nibble to 7-segment decoder; nibbles 10-15 show hex glyphs only when hex_mode is set.
module seg7_hex_decode
   import seg7_pkg::*;
(
   input  logic [3:0] nibble,
   input  logic       hex_mode,
   output logic [6:0] seg
);

   // Pattern lookup; every nibble value maps to a defined pattern
   always_comb begin
      seg = SEG_BLANK;
      case (nibble)
         4'd0:  seg = SEG_0;
         4'd1:  seg = SEG_1;
         4'd2:  seg = SEG_2;
         4'd3:  seg = SEG_3;
         4'd4:  seg = SEG_4;
         4'd5:  seg = SEG_5;
         4'd6:  seg = SEG_6;
         4'd7:  seg = SEG_7;
         4'd8:  seg = SEG_8;
         4'd9:  seg = SEG_9;
         4'd10: seg = hex_mode ? SEG_A : SEG_BLANK;
         4'd11: seg = hex_mode ? SEG_B : SEG_BLANK;
         4'd12: seg = hex_mode ? SEG_C : SEG_BLANK;
         4'd13: seg = hex_mode ? SEG_D : SEG_BLANK;
         4'd14: seg = hex_mode ? SEG_E : SEG_BLANK;
         4'd15: seg = hex_mode ? SEG_F : SEG_BLANK;
         default: seg = SEG_BLANK;
      endcase
   end

endmodule

// File: rtl/seg7_scan.sv
// Multiplexed 7-segment scanner: free-running prescaler and digit index, shadowed
// value/dp, optional leading-zero blanking, registered outputs with selectable polarity.
module seg7_scan
   import seg7_pkg::*;
#(
   parameter int NUM_DIGITS = 4,
   parameter int DIV        = 1000,
   parameter int HEX_MODE   = 1,
   parameter int ACTIVE_LOW = 0,
   parameter int LZB        = 0
)(
   input  logic                    clk,
   input  logic                    reset,
   input  logic [4*NUM_DIGITS-1:0] value,
   input  logic [NUM_DIGITS-1:0]   dp,
   input  logic                    load,
   input  logic                    enable,
   output logic [6:0]              leds,
   output logic                    dp_out,
   output logic [NUM_DIGITS-1:0]   digit_en
);

   localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
   localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

   localparam logic INV    = (ACTIVE_LOW != 0);
   localparam logic HEX_ON = (HEX_MODE != 0);
   localparam logic LZB_ON = (LZB != 0);

   logic [CNT_W-1:0]          cnt;
   logic [IDX_W-1:0]          idx;
   logic [4*NUM_DIGITS-1:0]   shadow_value;
   logic [NUM_DIGITS-1:0]     shadow_dp;
   logic                      tick;

   logic [3:0]                sel_nibble;
   logic                      sel_dp;
   logic                      sel_blank;
   logic [NUM_DIGITS-1:0]     sel_onehot;
   logic                      zero_above;
   logic [6:0]                dec_seg;
   logic [6:0]                seg_next;

   assign tick = (cnt == CNT_LAST);

   // Prescaler: counts 0..DIV-1 and wraps; the last count is the scan tick
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt <= '0;
      end else if (tick) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + CNT_ONE;
      end
   end

   // Digit index advances once per tick and wraps after the leftmost digit
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         idx <= '0;
      end else if (tick) begin
         idx <= (idx == IDX_LAST) ? '0 : idx + IDX_ONE;
      end
   end

   // Shadow registers: the decoder only ever sees captured data
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         shadow_value <= '0;
         shadow_dp    <= '0;
      end else if (load) begin
         shadow_value <= value;
         shadow_dp    <= dp;
      end
   end

   // Select the current digit and work out leading-zero blanking, scanning from the leftmost digit down
   always_comb begin
      sel_nibble = 4'd0;
      sel_dp     = 1'b0;
      sel_blank  = 1'b0;
      sel_onehot = '0;
      zero_above = 1'b1;
      for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
         zero_above = zero_above & (shadow_value[4*i +: 4] == 4'd0);
         if (idx == IDX_W'(i)) begin
            sel_nibble    = shadow_value[4*i +: 4];
            sel_dp        = shadow_dp[i];
            sel_onehot[i] = 1'b1;
            sel_blank     = LZB_ON && zero_above && (i != 0);
         end
      end
   end

   seg7_hex_decode u_dec (
      .nibble   (sel_nibble),
      .hex_mode (HEX_ON),
      .seg      (dec_seg)
   );

   assign seg_next = sel_blank ? SEG_BLANK : dec_seg;

   // Output registers: dark when disabled, polarity applied here so reset lands at the inactive level
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         leds     <= {7{INV}};
         dp_out   <= INV;
         digit_en <= {NUM_DIGITS{INV}};
      end else if (enable) begin
         leds     <= seg_next ^ {7{INV}};
         dp_out   <= sel_dp ^ INV;
         digit_en <= sel_onehot ^ {NUM_DIGITS{INV}};
      end else begin
         leds     <= {7{INV}};
         dp_out   <= INV;
         digit_en <= {NUM_DIGITS{INV}};
      end
   end

endmodule

// File: tb/tb_seg7_scan.sv
// Directed bench for seg7_scan: five instances share stimulus (default, decimal-only,
// leading-zero blanking, active-low, single digit), all with DIV=4.
module tb_seg7_scan;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [15:0] value = 16'h0000;
   logic [3:0]  dp = 4'b0000;
   logic        load = 1'b0;
   logic        enable = 1'b0;

   logic [6:0] a_leds, b_leds, c_leds, d_leds, e_leds;
   logic       a_dp, b_dp, c_dp, d_dp, e_dp;
   logic [3:0] a_en, b_en, c_en, d_en;
   logic [0:0] e_en;

   int total = 0;
   int bad   = 0;
   int k     = 0;   // clock edges since last reset release

   always #5 clk = ~clk;

   seg7_scan #(.NUM_DIGITS(4), .DIV(4), .HEX_MODE(1), .ACTIVE_LOW(0), .LZB(0)) dut_a (
      .clk(clk), .reset(reset), .value(value), .dp(dp), .load(load), .enable(enable),
      .leds(a_leds), .dp_out(a_dp), .digit_en(a_en));
   seg7_scan #(.NUM_DIGITS(4), .DIV(4), .HEX_MODE(0), .ACTIVE_LOW(0), .LZB(0)) dut_b (
      .clk(clk), .reset(reset), .value(value), .dp(dp), .load(load), .enable(enable),
      .leds(b_leds), .dp_out(b_dp), .digit_en(b_en));
   seg7_scan #(.NUM_DIGITS(4), .DIV(4), .HEX_MODE(1), .ACTIVE_LOW(0), .LZB(1)) dut_c (
      .clk(clk), .reset(reset), .value(value), .dp(dp), .load(load), .enable(enable),
      .leds(c_leds), .dp_out(c_dp), .digit_en(c_en));
   seg7_scan #(.NUM_DIGITS(4), .DIV(4), .HEX_MODE(1), .ACTIVE_LOW(1), .LZB(0)) dut_d (
      .clk(clk), .reset(reset), .value(value), .dp(dp), .load(load), .enable(enable),
      .leds(d_leds), .dp_out(d_dp), .digit_en(d_en));
   seg7_scan #(.NUM_DIGITS(1), .DIV(4), .HEX_MODE(1), .ACTIVE_LOW(0), .LZB(0)) dut_e (
      .clk(clk), .reset(reset), .value(value[3:0]), .dp(dp[0:0]), .load(load), .enable(enable),
      .leds(e_leds), .dp_out(e_dp), .digit_en(e_en));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      k++;
   endtask

   // Expected lit state: digit shown after edge k is ((k-1)/4)%4 (tick every 4th edge, one-cycle output latency)
   task automatic check_lit(input logic [3:0][6:0] ta, input logic [3:0][6:0] tb_, input logic [3:0][6:0] tc,
                            input logic [3:0] p);
      int d;
      logic [3:0] en, en_n;
      logic [6:0] la, la_n;
      logic dpx, dpn;
      d    = ((k - 1) / 4) % 4;
      en   = 4'b0001 << d;
      en_n = ~en;
      la   = ta[d];
      la_n = ~la;
      dpx  = p[d];
      dpn  = ~dpx;
      chk("a_en", a_en, en);
      chk("a_leds", a_leds, la);
      chk("a_dp", a_dp, dpx);
      chk("b_en", b_en, en);
      chk("b_leds", b_leds, tb_[d]);
      chk("b_dp", b_dp, dpx);
      chk("c_en", c_en, en);
      chk("c_leds", c_leds, tc[d]);
      chk("c_dp", c_dp, dpx);
      chk("d_en", d_en, en_n);
      chk("d_leds", d_leds, la_n);
      chk("d_dp", d_dp, dpn);
      chk("e_en", e_en, 1);
      chk("e_leds", e_leds, ta[0]);
      chk("e_dp", e_dp, p[0]);
   endtask

   task automatic check_dark(input string tag);
      chk({tag, "_a_en"}, a_en, 4'b0000);
      chk({tag, "_a_leds"}, a_leds, 7'b0000000);
      chk({tag, "_a_dp"}, a_dp, 1'b0);
      chk({tag, "_c_leds"}, c_leds, 7'b0000000);
      chk({tag, "_d_en"}, d_en, 4'b1111);
      chk({tag, "_d_leds"}, d_leds, 7'b1111111);
      chk({tag, "_d_dp"}, d_dp, 1'b1);
      chk({tag, "_e_en"}, e_en, 1'b0);
   endtask

   // Load a new value, then check n edges of the scan
   task automatic phase(input logic [15:0] v, input logic [3:0] p, input logic [3:0][6:0] ta,
                        input logic [3:0][6:0] tb_, input logic [3:0][6:0] tc, input int n);
      value = v;
      dp    = p;
      load  = 1'b1;
      step();
      load  = 1'b0;
      repeat (n) begin
         step();
         check_lit(ta, tb_, tc, p);
      end
   endtask

   // Pattern tables {digit3, digit2, digit1, digit0}
   localparam logic [3:0][6:0] T_1234   = {7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011};
   localparam logic [3:0][6:0] T_AF_HEX = {7'b1111110, 7'b1111110, 7'b1110111, 7'b1000111};
   localparam logic [3:0][6:0] T_AF_DEC = {7'b1111110, 7'b1111110, 7'b0000000, 7'b0000000};
   localparam logic [3:0][6:0] T_AF_LZB = {7'b0000000, 7'b0000000, 7'b1110111, 7'b1000111};
   localparam logic [3:0][6:0] T_50     = {7'b1111110, 7'b1111110, 7'b1011011, 7'b1111110};
   localparam logic [3:0][6:0] T_50_LZB = {7'b0000000, 7'b0000000, 7'b1011011, 7'b1111110};
   localparam logic [3:0][6:0] T_00     = {7'b1111110, 7'b1111110, 7'b1111110, 7'b1111110};
   localparam logic [3:0][6:0] T_00_LZB = {7'b0000000, 7'b0000000, 7'b0000000, 7'b1111110};
   localparam logic [3:0][6:0] T_2222   = {7'b1101101, 7'b1101101, 7'b1101101, 7'b1101101};
   localparam logic [3:0][6:0] T_1111   = {7'b0110000, 7'b0110000, 7'b0110000, 7'b0110000};

   initial begin
      // Asynchronous reset before any clock edge
      #2 reset = 1'b1;
      #1 check_dark("rst_async");
      step();
      check_dark("rst_held");
      step();
      reset  = 1'b0;
      k      = 0;
      value  = 16'h1234;
      dp     = 4'b0100;
      load   = 1'b1;
      enable = 1'b1;

      // First edge after release shows digit 0 (old shadow still zero)
      step();
      chk("first_en", a_en, 4'b0001);
      chk("first_leds", a_leds, 7'b1111110);
      chk("first_d_en", d_en, 4'b1110);
      load = 1'b0;
      repeat (16) begin
         step();
         check_lit(T_1234, T_1234, T_1234, 4'b0100);
      end

      // Hex versus decimal-only decode
      phase(16'h00AF, 4'b0001, T_AF_HEX, T_AF_DEC, T_AF_LZB, 16);
      // Leading-zero blanking; dp on a blanked digit still shows
      phase(16'h0050, 4'b1000, T_50, T_50, T_50_LZB, 16);
      phase(16'h0000, 4'b0000, T_00, T_00, T_00_LZB, 16);

      // Load coinciding with a tick
      phase(16'h2222, 4'b0010, T_2222, T_2222, T_2222, 6);
      repeat (4) begin
         if (((k + 1) % 4) != 0) begin
            step();
            check_lit(T_2222, T_2222, T_2222, 4'b0010);
         end
      end
      value = 16'h1111;
      dp    = 4'b0000;
      load  = 1'b1;
      step();
      chk("tick_load_old", a_leds, 7'b1101101);
      load = 1'b0;
      step();
      chk("tick_load_new", a_leds, 7'b0110000);
      check_lit(T_1111, T_1111, T_1111, 4'b0000);

      // Enable toggled mid-dwell; scan position keeps running underneath
      repeat (4) begin
         if ((k % 4) != 2) step();
      end
      enable = 1'b0;
      step();
      check_dark("dis1");
      step();
      check_dark("dis2");
      enable = 1'b1;
      repeat (6) begin
         step();
         check_lit(T_1111, T_1111, T_1111, 4'b0000);
      end

      // Reset mid-scan while a non-zero digit is showing
      repeat (16) begin
         if (((k - 1) / 4) % 4 != 2) step();
      end
      chk("pre_rst_en", a_en, 4'b0100);
      reset = 1'b1;
      #1 check_dark("rst_mid");
      step();
      check_dark("rst_mid_held");
      reset = 1'b0;
      k     = 0;
      repeat (8) begin
         step();
         check_lit(T_00, T_00, T_00_LZB, 4'b0000);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/seg7_scan.md
SEG7_SCAN -- requirements
Module: seg7_scan

Interface
REQ-001 Parameter NUM_DIGITS, default 4: number of multiplexed digits (1..8).
REQ-002 Parameter DIV, default 1000: clock cycles each digit is driven before the scan advances (>=2).
REQ-003 Parameter HEX_MODE, default 1: 1 shows nibbles A-F as hex glyphs; 0 blanks nibbles 10-15.
REQ-004 Parameter ACTIVE_LOW, default 0: 1 inverts leds, dp_out and digit_en at the output registers.
REQ-005 Parameter LZB, default 0: 1 enables leading-zero blanking.
REQ-006 clk  in  1  single clock; all state updates on its rising edge.
REQ-007 reset  in  1  asynchronous, active-high reset.
REQ-008 value  in  4*NUM_DIGITS  one BCD/hex nibble per digit; nibble 0 (bits 3:0) is the rightmost digit.
REQ-009 dp  in  NUM_DIGITS  decimal-point request per digit.
REQ-010 load  in  1  capture value and dp into shadow registers on this cycle.
REQ-011 enable  in  1  0 forces the display dark.
REQ-012 leds  out  7  segments a..g, MSB = a, registered.
REQ-013 dp_out  out  1  decimal point of the selected digit, registered.
REQ-014 digit_en  out  NUM_DIGITS  one-hot digit select, registered.

Function
REQ-015 Prescaler counts 0..DIV-1 and wraps; the cycle where it equals DIV-1 is the tick.
REQ-016 On tick, digit index advances by 1; from NUM_DIGITS-1 it wraps to 0.
REQ-017 load=1 copies value/dp into shadow registers at that edge; decode uses shadow contents only; no load leaves the shadow unchanged.
REQ-018 load coinciding with tick: both take effect at the same edge; the new index is decoded from the new shadow.
REQ-019 Output registers take their value from the current index and shadow: one cycle latency from an index or shadow change to the output.
REQ-020 Decode (abcdefg, active-high): 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011, 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011.
REQ-021 HEX_MODE=1: A=1110111, b=0011111, C=1001110, d=0111101, E=1001111, F=1000111; HEX_MODE=0: 10-15 give 0000000. Never X.
REQ-022 LZB=1: a digit is blanked (leds 0000000) if it and every higher digit are zero; digit 0 is never blanked; dp is unaffected.
REQ-023 enable=0: digit_en, leds, dp_out all inactive from the next edge; prescaler and index keep running.
REQ-024 Exactly one digit_en bit is active whenever enable=1 and the block is out of reset.
REQ-025 NUM_DIGITS=1: index stays 0; digit_en constantly active when enabled.

Reset
REQ-026 reset asserted: prescaler=0, index=0, shadow value=0, shadow dp=0 immediately, without a clock edge.
REQ-027 reset asserted: leds, dp_out, digit_en at inactive level (all 0 if ACTIVE_LOW=0, all 1 if ACTIVE_LOW=1).
REQ-028 After reset release, the first active output is digit 0, on the first clk edge with enable=1.

Structure
REQ-029 Package seg7_pkg holds the 16 segment-pattern constants and the blank pattern.
REQ-030 Combinational sub-module seg7_hex_decode (nibble, hex_mode -> 7 segments) performs the decode; scan, shadow and polarity logic stay in seg7_scan.

Verification
REQ-031 NUM_DIGITS=4, DIV=4, load value=16'h1234, enable=1 -> digit_en 0001,0010,0100,1000 for 4 cycles each; leds 0110011, 1111001, 1101101, 0110000; then wraps to 0001.
REQ-032 HEX_MODE=0, load 16'h00AF -> digits 0 and 1 show 0000000; HEX_MODE=1 -> 1000111 (F) and 1110111 (A).
REQ-033 LZB=1, load 16'h0050 -> digits 3 and 2 blank, digit 1 shows 1011011, digit 0 shows 1111110; load 16'h0000 -> only digit 0 lit, showing 1111110.
REQ-034 load 16'h1111 asserted on a tick cycle, while 16'h2222 was displayed -> the next digit's output shows 0110000 one cycle later, with no stale 1101101 on that digit.
REQ-035 ACTIVE_LOW=1: assert reset mid-scan -> outputs all 1 immediately; prescaler and index at 0; after release, first lit digit is digit 0.
REQ-036 enable toggled 1->0->1 mid-dwell -> outputs dark for the 0 cycles; on re-enable the scan resumes at the index the free-running counter has reached.
